// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//
// Sequential front-end for the combinational 32-bit CPU ALU. A request taken
// over the req_* valid/ready handshake is registered onto the alu_* operand
// outputs. After SETTLE cycles the ALU result and zero flag are captured. They
// are returned with the request tag over the rsp_* valid/ready handshake.
// A request may replace req_a with the previously captured result (chaining)
// to build multi-step accumulations.
//
// Parameters
//   SETTLE  ALU settle cycles between operand load and capture (1..15)
//   TAG_W   request/response tag width
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid / req_ready          request handshake (ready only in IDLE)
//   req_op, req_a..req_d, req_sel  opcode, operands and sel for the ALU
//   req_chain                      use chain register instead of req_a
//   req_tag                        echoed back on rsp_tag
//   alu_op, alu_in1..4, alu_sel    registered drive into the ALU
//   alu_out, alu_zero              ALU result inputs
//   rsp_valid / rsp_ready          response handshake
//   rsp_data, rsp_zero             captured ALU result and zero flag
//   rsp_illegal                    request opcode was 0xF
//   rsp_tag                        tag of the answered request
//   busy                           FSM is not IDLE
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int SETTLE = 1,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [31:0]      req_c,
    input  logic [31:0]      req_d,
    input  logic             req_sel,
    input  logic             req_chain,
    input  logic [TAG_W-1:0] req_tag,

    output logic [3:0]       alu_op,
    output logic [31:0]      alu_in1,
    output logic [31:0]      alu_in2,
    output logic [31:0]      alu_in3,
    output logic [31:0]      alu_in4,
    output logic             alu_sel,
    input  logic [31:0]      alu_out,
    input  logic             alu_zero,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             rsp_zero,
    output logic             rsp_illegal,
    output logic [TAG_W-1:0] rsp_tag,

    output logic             busy
);

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);
    localparam logic [3:0] OP_ILLEGAL = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [3:0]         settle_cnt;
    logic [31:0]        chain_q;
    logic [TAG_W-1:0]   tag_q;
    logic               illegal_q;
    logic               load_en;
    logic               cap_en;
    logic               rsp_done;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. WAIT leaves when the counter shows 1, so the counter
    // never has to pass through 0; SETTLE=1 gives a single WAIT cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (req_valid)        state_nxt = S_WAIT;
            S_WAIT:    if (settle_cnt <= 4'd1) state_nxt = S_CAPTURE;
            S_CAPTURE:                       state_nxt = S_RESP;
            S_RESP:    if (rsp_ready)        state_nxt = S_IDLE;
            default:                         state_nxt = S_IDLE;
        endcase
    end

    // Output / control decode. req_ready depends on state only.
    always_comb begin
        req_ready = (state == S_IDLE);
        busy      = (state != S_IDLE);
        load_en   = (state == S_IDLE) && req_valid;
        cap_en    = (state == S_CAPTURE);
        rsp_done  = (state == S_RESP) && rsp_ready;
    end

    // Settle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= 4'd0;
        end else if (load_en) begin
            settle_cnt <= SETTLE_CNT;
        end else if ((state == S_WAIT) && (settle_cnt > 4'd1)) begin
            settle_cnt <= settle_cnt - 4'd1;
        end
    end

    // Operand issue: held until the next accepted request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op    <= 4'd0;
            alu_in1   <= 32'd0;
            alu_in2   <= 32'd0;
            alu_in3   <= 32'd0;
            alu_in4   <= 32'd0;
            alu_sel   <= 1'b0;
            tag_q     <= '0;
            illegal_q <= 1'b0;
        end else if (load_en) begin
            alu_op    <= req_op;
            alu_in1   <= req_chain ? chain_q : req_a;
            alu_in2   <= req_b;
            alu_in3   <= req_c;
            alu_in4   <= req_d;
            alu_sel   <= req_sel;
            tag_q     <= req_tag;
            illegal_q <= (req_op == OP_ILLEGAL);
        end
    end

    // Result capture: rsp_* only change at capture, so they stay stable
    // throughout RESP under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data    <= 32'd0;
            rsp_zero    <= 1'b0;
            rsp_illegal <= 1'b0;
            rsp_tag     <= '0;
            chain_q     <= 32'd0;
        end else if (cap_en) begin
            rsp_data    <= alu_out;
            rsp_zero    <= alu_zero;
            rsp_illegal <= illegal_q;
            rsp_tag     <= tag_q;
            chain_q     <= alu_out;
        end
    end

    // Response valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
        end else if (cap_en) begin
            rsp_valid <= 1'b1;
        end else if (rsp_done) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule
